// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, no-write-allocate read cache
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   address      in   mapped byte address; [2] word-in-block, [INDEX_W+2:3] set, [TAG_W+INDEX_W+2:INDEX_W+3] tag
//   wdata        in   store data
//   rd_en/wr_en  in   load/store request, held stable while ready=0; wr_en wins over rd_en
//   rdata        out  load data, valid when rd_en & ready
//   ready        out  request done this cycle or idle; 0 stalls the pipeline
//   sram_*       to/from SRAM controller: 64-bit block reads, 32-bit word writes, sram_ready pulse on completion
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WR_THRU = 2'd2;
    localparam int SETS = 1 << INDEX_W;

    logic [1:0]         state, nxt;
    logic [SETS-1:0]    valid0, valid1, lru;
    logic [TAG_W-1:0]   tag0 [SETS];
    logic [TAG_W-1:0]   tag1 [SETS];
    logic [63:0]        data0 [SETS];
    logic [63:0]        data1 [SETS];
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic [63:0]        hit_blk, new_blk;
    logic               wsel, hit0, hit1, hit, busy, victim, fill, upd, lru_we, lru_val;
    logic               unused;

    always_comb begin
        idx     = address[INDEX_W+2:3];
        tg      = address[TAG_W+INDEX_W+2:INDEX_W+3];
        wsel    = address[2];
        unused  = &{1'b0, address[1:0], address[31:TAG_W+INDEX_W+3]};
        hit0    = valid0[idx] && tag0[idx] == tg;
        hit1    = valid1[idx] && tag1[idx] == tg;
        hit     = hit0 || hit1;
        hit_blk = hit1 ? data1[idx] : data0[idx];
        busy    = state == RD_MISS || state == WR_THRU;
        // prefer an empty way (way 0 first) before evicting the LRU way
        victim  = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
        fill    = state == RD_MISS && sram_ready;
        // write hit is judged at completion, after any intervening fills
        upd     = state == WR_THRU && sram_ready && hit;
        lru_we  = fill || upd || (!busy && !wr_en && rd_en && hit);
        lru_val = fill ? !victim : hit0;
        new_blk = fill ? sram_rdata : wsel ? {wdata, hit_blk[31:0]} : {hit_blk[63:32], wdata};
        nxt     = busy ? (sram_ready ? IDLE : state) : wr_en ? WR_THRU : (rd_en && !hit) ? RD_MISS : IDLE;
        ready   = busy ? sram_ready : !wr_en && !(rd_en && !hit);
        sram_rd_en   = state == RD_MISS ? !sram_ready : !busy && !wr_en && rd_en && !hit;
        sram_wr_en   = state == WR_THRU ? !sram_ready : !busy && wr_en;
        sram_address = wr_en ? {address[31:2], 2'b0} : {address[31:3], 3'b0};
        sram_wdata   = wdata;
        // miss completion bypasses the fetched block straight to the pipeline
        rdata = state == RD_MISS ? (wsel ? sram_rdata[63:32] : sram_rdata[31:0])
                                 : (wsel ? hit_blk[63:32] : hit_blk[31:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            state <= nxt;
            if (lru_we) lru[idx] <= lru_val;
            if (fill && !victim) valid0[idx] <= 1'b1;
            if (fill && victim) valid1[idx] <= 1'b1;
        end
    end

    // tag/data arrays are not reset; valid bits guard them
    always_ff @(posedge clk) begin
        if ((fill && !victim) || (upd && hit0)) data0[idx] <= new_blk;
        if ((fill && victim) || (upd && !hit0)) data1[idx] <= new_blk;
        if (fill && !victim) tag0[idx] <= tg;
        if (fill && victim) tag1[idx] <= tg;
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard-driven bench for cache_controller
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    cache_controller dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata), .rd_en(rd_en), .wr_en(wr_en),
        .rdata(rdata), .ready(ready), .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_read(input logic [31:0] a, input bit exp_hit, input int lat, input logic [63:0] blk, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        address = a; rd_en = 1'b1; wr_en = 1'b0; sram_ready = 1'b0;
        sb.push_back(exp);
        #1;
        if (exp_hit) begin
            checks++; if ({ready, sram_rd_en} !== 2'b10) begin errors++; $display("FAIL rd_hit %h ready/sram_rd_en got %b exp 10", a, {ready, sram_rd_en}); end
        end else begin
            checks++; if ({ready, sram_rd_en} !== 2'b01) begin errors++; $display("FAIL rd_issue %h ready/sram_rd_en got %b exp 01", a, {ready, sram_rd_en}); end
            checks++; if (sram_address !== {a[31:3], 3'b0}) begin errors++; $display("FAIL rd_addr %h got %h exp %h", a, sram_address, {a[31:3], 3'b0}); end
            repeat (lat) begin
                @(negedge clk); #1;
                checks++; if ({ready, sram_rd_en} !== 2'b01) begin errors++; $display("FAIL rd_wait %h ready/sram_rd_en got %b exp 01", a, {ready, sram_rd_en}); end
            end
            @(negedge clk);
            sram_ready = 1'b1; sram_rdata = blk;
            #1;
            checks++; if ({ready, sram_rd_en} !== 2'b10) begin errors++; $display("FAIL rd_done %h ready/sram_rd_en got %b exp 10", a, {ready, sram_rd_en}); end
        end
        e = sb.pop_front();
        checks++; if (rdata !== e) begin errors++; $display("FAIL rd_data %h got %h exp %h", a, rdata, e); end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both, input int lat);
        @(negedge clk);
        address = a; wdata = d; wr_en = 1'b1; rd_en = both; sram_ready = 1'b0;
        #1;
        checks++; if ({ready, sram_wr_en, sram_rd_en} !== 3'b010) begin errors++; $display("FAIL wr_issue %h ready/wr/rd got %b exp 010", a, {ready, sram_wr_en, sram_rd_en}); end
        checks++; if (sram_address !== {a[31:2], 2'b0} || sram_wdata !== d) begin errors++; $display("FAIL wr_bus %h addr got %h data got %h exp %h %h", a, sram_address, sram_wdata, {a[31:2], 2'b0}, d); end
        repeat (lat) begin
            @(negedge clk); #1;
            checks++; if ({ready, sram_wr_en, sram_rd_en} !== 3'b010) begin errors++; $display("FAIL wr_wait %h ready/wr/rd got %b exp 010", a, {ready, sram_wr_en, sram_rd_en}); end
        end
        @(negedge clk);
        sram_ready = 1'b1;
        #1;
        checks++; if ({ready, sram_wr_en, sram_rd_en} !== 3'b100) begin errors++; $display("FAIL wr_done %h ready/wr/rd got %b exp 100", a, {ready, sram_wr_en, sram_rd_en}); end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) begin
            @(negedge clk); #1;
            checks++; if ({ready, sram_rd_en, sram_wr_en} !== 3'b100) begin errors++; $display("FAIL idle ready/rd/wr got %b exp 100", {ready, sram_rd_en, sram_wr_en}); end
        end
    endtask

    task automatic test_cold_read();
        do_read(32'h208, 1'b0, 1, 64'hBBBBBBBB_AAAAAAAA, 32'hAAAAAAAA);
        do_read(32'h20C, 1'b1, 0, 64'h0, 32'hBBBBBBBB);
    endtask

    task automatic test_conflict_lru();
        do_reset();
        do_read(32'h008, 1'b0, 0, 64'h10001000_00080008, 32'h00080008);
        do_read(32'h208, 1'b0, 2, 64'h21212121_02080208, 32'h02080208);
        do_read(32'h00C, 1'b1, 0, 64'h0, 32'h10001000);
        do_read(32'h408, 1'b0, 1, 64'h44444444_04080408, 32'h04080408);
        do_read(32'h008, 1'b1, 0, 64'h0, 32'h00080008);
        do_read(32'h20C, 1'b0, 3, 64'h22222222_02080208, 32'h22222222);
    endtask

    task automatic test_write_hit();
        do_write(32'h20C, 32'h12345678, 1'b0, 2);
        do_read(32'h20C, 1'b1, 0, 64'h0, 32'h12345678);
        do_read(32'h208, 1'b1, 0, 64'h0, 32'h02080208);
        do_read(32'h8020C, 1'b1, 0, 64'h0, 32'h12345678);
    endtask

    task automatic test_write_wins();
        do_write(32'h20C, 32'h55AA55AA, 1'b1, 0);
        do_read(32'h20C, 1'b1, 0, 64'h0, 32'h55AA55AA);
    endtask

    task automatic test_write_miss();
        do_write(32'h608, 32'hCAFEF00D, 1'b0, 1);
        do_read(32'h608, 1'b0, 1, 64'h66666666_60606060, 32'h60606060);
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        address = 32'h1008; rd_en = 1'b1; wr_en = 1'b0; sram_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if ({ready, sram_rd_en} !== 2'b01) begin errors++; $display("FAIL mid_miss ready/sram_rd_en got %b exp 01", {ready, sram_rd_en}); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; rd_en = 1'b0;
        #1;
        checks++; if ({ready, sram_rd_en, sram_wr_en} !== 3'b100) begin errors++; $display("FAIL post_reset ready/rd/wr got %b exp 100", {ready, sram_rd_en, sram_wr_en}); end
        do_read(32'h20C, 1'b0, 1, 64'h77777777_70707070, 32'h77777777);
    endtask

    task automatic test_back_to_back();
        do_read(32'h208, 1'b1, 0, 64'h0, 32'h70707070);
        do_read(32'h20C, 1'b1, 0, 64'h0, 32'h77777777);
        do_write(32'h208, 32'hDEADBEEF, 1'b0, 0);
        do_read(32'h208, 1'b1, 0, 64'h0, 32'hDEADBEEF);
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_conflict_lru();
        test_write_hit();
        test_write_wins();
        test_write_miss();
        test_reset_mid_miss();
        test_back_to_back();
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
